// File: rtl/abc2dq_pkg.sv
// Shared definitions for the abc -> alpha/beta -> d/q current transform.
package abc2dq_pkg;

  // Default data width and number of fractional bits (Q1.15).
  localparam int DEF_W = 16;
  localparam int DEF_F = 15;

  // 1/sqrt(3) in Q1.15, always used as a positive coefficient.
  localparam logic [15:0] INV_SQRT3 = 16'd18919;

  // One state per sequencing step; each step uses the shared multiplier once.
  typedef enum logic [2:0] {
    IDLE,
    BETA,
    M0,
    M1,
    M2,
    M3
  } state_t;

  // Clamp a wide signed value into the signed range of 'width' bits.
  // The caller truncates the result to its own width.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                  input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (x > max_v) begin
      return max_v;
    end else if (x < min_v) begin
      return min_v;
    end
    return x;
  endfunction

endpackage

// File: rtl/abc2dq_mac.sv
// Registered signed multiply-accumulate shared by every step of the transform.
// sum is the combinational next accumulator value (clear ? 0 : acc) +/- a*b,
// so the sequencer can saturate it on the same edge it is stored.
module abc2dq_mac #(
  parameter int a_width   = 18,
  parameter int b_width   = 17,
  parameter int acc_width = 34
) (
  input  logic                        clk,
  input  logic                        srst,
  input  logic                        en,
  input  logic                        clear,
  input  logic                        negate,
  input  logic signed [a_width-1:0]   a,
  input  logic signed [b_width-1:0]   b,
  output logic signed [acc_width-1:0] sum
);

  logic signed [a_width+b_width-1:0] prod;
  logic signed [acc_width-1:0]       prod_t;
  logic signed [acc_width-1:0]       term;
  logic signed [acc_width-1:0]       base;
  logic signed [acc_width-1:0]       acc_reg;

  // Product, optional negation and accumulate-or-restart.
  // The product never exceeds acc_width bits for the operand ranges used,
  // so dropping the top product bits is lossless.
  always_comb begin
    prod   = a * b;
    prod_t = $signed(prod[acc_width-1:0]);
    term   = negate ? -prod_t : prod_t;
    base   = clear ? '0 : acc_reg;
    sum    = base + term;
  end

  // Accumulator register, updated only on active sequencing steps.
  always_ff @(posedge clk) begin
    if (srst) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= sum;
    end
  end

endmodule

// File: rtl/abc2dq_seq.sv
// Forward current transform: (ia, ib) -> Clarke (alpha, beta) -> Park (d, q)
// using supplied sin/cos of the electrical angle. A single shared multiplier
// is stepped through five products by a small FSM; one sample per 6 cycles.
module abc2dq_seq
  import abc2dq_pkg::*;
#(
  parameter int                     inout_width         = DEF_W,
  parameter int                     inout_decimal_width = DEF_F,
  parameter logic [inout_width-1:0] inv_sqrt3           = inout_width'(INV_SQRT3)
) (
  input  logic                   aclk,
  input  logic                   reset,
  input  logic [inout_width-1:0] ia,
  input  logic [inout_width-1:0] ib,
  input  logic [inout_width-1:0] sin,
  input  logic [inout_width-1:0] cos,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [inout_width-1:0] alpha,
  output logic [inout_width-1:0] beta,
  output logic [inout_width-1:0] d,
  output logic [inout_width-1:0] q,
  output logic                   out_valid
);

  localparam int W    = inout_width;
  localparam int F    = inout_decimal_width;
  localparam int AW   = W + 2;      // holds ia + 2*ib
  localparam int BW   = W + 1;      // holds positive inv_sqrt3 as signed
  localparam int ACCW = 2 * W + 2;

  state_t state_reg;
  state_t state_next;

  logic signed [W-1:0]    ia_reg;
  logic signed [W-1:0]    ib_reg;
  logic signed [W-1:0]    sin_reg;
  logic signed [W-1:0]    cos_reg;
  logic signed [W-1:0]    beta_reg;
  logic signed [W-1:0]    d_reg;

  logic signed [AW-1:0]   sum_ab;
  logic signed [ACCW-1:0] mac_sum;
  logic signed [ACCW-1:0] mac_shifted;
  logic signed [W-1:0]    sat_res;

  logic                   mac_en;
  logic                   mac_clear;
  logic                   mac_negate;
  logic signed [AW-1:0]   mac_a;
  logic signed [BW-1:0]   mac_b;

  abc2dq_mac #(
    .a_width  (AW),
    .b_width  (BW),
    .acc_width(ACCW)
  ) u_mac (
    .clk   (aclk),
    .srst  (reset),
    .en    (mac_en),
    .clear (mac_clear),
    .negate(mac_negate),
    .a     (mac_a),
    .b     (mac_b),
    .sum   (mac_sum)
  );

  assign in_ready = (state_reg == IDLE);

  // ia + 2*ib in W+2 bits, then rescale and clamp whatever the MAC produces.
  always_comb begin
    sum_ab      = AW'(ia_reg) + (AW'(ib_reg) <<< 1);
    mac_shifted = mac_sum >>> F;
    sat_res     = W'(saturate(64'(mac_shifted), W));
  end

  // Next-state and multiplier operand/control selection for each step.
  always_comb begin
    state_next = state_reg;
    mac_en     = 1'b0;
    mac_clear  = 1'b0;
    mac_negate = 1'b0;
    mac_a      = '0;
    mac_b      = '0;
    case (state_reg)
      IDLE: begin
        if (in_valid) state_next = BETA;
      end
      BETA: begin  // (ia + 2*ib) * inv_sqrt3
        mac_en     = 1'b1;
        mac_clear  = 1'b1;
        mac_a      = sum_ab;
        mac_b      = $signed({1'b0, inv_sqrt3});
        state_next = M0;
      end
      M0: begin    // acc = alpha * cos
        mac_en     = 1'b1;
        mac_clear  = 1'b1;
        mac_a      = AW'(ia_reg);
        mac_b      = BW'(cos_reg);
        state_next = M1;
      end
      M1: begin    // d = acc + beta * sin
        mac_en     = 1'b1;
        mac_a      = AW'(beta_reg);
        mac_b      = BW'(sin_reg);
        state_next = M2;
      end
      M2: begin    // acc = -(alpha * sin)
        mac_en     = 1'b1;
        mac_clear  = 1'b1;
        mac_negate = 1'b1;
        mac_a      = AW'(ia_reg);
        mac_b      = BW'(sin_reg);
        state_next = M3;
      end
      M3: begin    // q = acc + beta * cos
        mac_en     = 1'b1;
        mac_a      = AW'(beta_reg);
        mac_b      = BW'(cos_reg);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, input capture, intermediate results and output load.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_reg <= IDLE;
      ia_reg    <= '0;
      ib_reg    <= '0;
      sin_reg   <= '0;
      cos_reg   <= '0;
      beta_reg  <= '0;
      d_reg     <= '0;
      alpha     <= '0;
      beta      <= '0;
      d         <= '0;
      q         <= '0;
      out_valid <= 1'b0;
    end else begin
      state_reg <= state_next;
      out_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            ia_reg  <= $signed(ia);
            ib_reg  <= $signed(ib);
            sin_reg <= $signed(sin);
            cos_reg <= $signed(cos);
          end
        end
        BETA: beta_reg <= sat_res;
        M1:   d_reg    <= sat_res;
        M3: begin
          alpha     <= ia_reg;
          beta      <= beta_reg;
          d         <= d_reg;
          q         <= sat_res;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_abc2dq_seq.sv
// Scoreboard bench for abc2dq_seq: directed test-plan cases plus random
// samples, with expected values from a plain-arithmetic reference model.
module tb_abc2dq_seq;

  logic        aclk = 1'b0;
  logic        reset;
  logic [15:0] ia, ib, sin, cos;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] alpha, beta, d, q;
  logic        out_valid;

  abc2dq_seq dut (
    .aclk     (aclk),
    .reset    (reset),
    .ia       (ia),
    .ib       (ib),
    .sin      (sin),
    .cos      (cos),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alpha    (alpha),
    .beta     (beta),
    .d        (d),
    .q        (q),
    .out_valid(out_valid)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    longint a, b, d, q;
    int     cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   strobes = 0;
  int   last_acc = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic longint sat16(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // Clarke then Park with floor (>>>) rescaling and saturation.
  function automatic exp_t model(input logic [15:0] a16, b16, s16, c16);
    exp_t   e;
    longint a, b, s, c, be;
    a   = longint'($signed(a16));
    b   = longint'($signed(b16));
    s   = longint'($signed(s16));
    c   = longint'($signed(c16));
    be  = sat16(((a + 2 * b) * 18919) >>> 15);
    e.a = a;
    e.b = be;
    e.d = sat16((a * c + be * s) >>> 15);
    e.q = sat16((be * c - a * s) >>> 15);
    e.cyc = 0;
    return e;
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7fff;
      default: return 16'($urandom);
    endcase
  endfunction

  // Present a sample and wait for acceptance; optionally keep in_valid high.
  task automatic send(input logic [15:0] a, b, s, c, input bit track, input bit hold);
    exp_t e;
    bit   got;
    ia = a; ib = b; sin = s; cos = c; in_valid = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge aclk);
      if (in_ready) got = 1'b1;
    end
    chk("accept_timeout", longint'(got), 1);
    @(posedge aclk);
    #1;
    last_acc = cyc;
    if (track) begin
      e = model(a, b, s, c);
      e.cyc = cyc + 5;
      exp_q.push_back(e);
    end
    $display("in  cyc=%0d ia=%0d ib=%0d sin=%0d cos=%0d", cyc,
             $signed(a), $signed(b), $signed(s), $signed(c));
    if (!hold) in_valid = 1'b0;
  endtask

  // Monitor: every strobe pops one expected result and compares it.
  always @(negedge aclk) begin
    exp_t e;
    if (!reset && out_valid) begin
      strobes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        $display("out cyc=%0d alpha=%0d beta=%0d d=%0d q=%0d", cyc,
                 $signed(alpha), $signed(beta), $signed(d), $signed(q));
        chk("alpha", longint'($signed(alpha)), e.a);
        chk("beta", longint'($signed(beta)), e.b);
        chk("d", longint'($signed(d)), e.d);
        chk("q", longint'($signed(q)), e.q);
        chk("latency", longint'(cyc), longint'(e.cyc));
        chk("ready_with_strobe", longint'(in_ready), 1);
      end
    end
  end

  initial begin
    int s0, acc1;
    reset = 1'b1; in_valid = 1'b0;
    ia = '0; ib = '0; sin = '0; cos = '0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_alpha", longint'(alpha), 0);
    chk("rst_d", longint'(d), 0);
    chk("rst_q", longint'(q), 0);
    reset = 1'b0;

    // Pure a-axis, b-only, saturation cases.
    send(16'd16384, -16'sd8192, 16'd0, 16'd32767, 1'b1, 1'b0);
    send(16'd0, 16'd16384, 16'd0, 16'd32767, 1'b1, 1'b0);
    send(16'h8000, 16'h8000, 16'd0, 16'h8000, 1'b1, 1'b0);
    send(16'h7fff, 16'h7fff, 16'd0, 16'h7fff, 1'b1, 1'b0);

    // Busy: second pulse during processing must be ignored.
    repeat (8) @(posedge aclk);
    #1;
    s0 = strobes;
    send(16'd0, 16'd16384, 16'd0, 16'd32767, 1'b1, 1'b0);
    @(posedge aclk); #1;
    ia = 16'h1234; ib = 16'h4321; sin = 16'h7000; cos = 16'h0100; in_valid = 1'b1;
    chk("busy_in_ready", longint'(in_ready), 0);
    @(posedge aclk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge aclk);
    #1;
    chk("busy_one_strobe", longint'(strobes - s0), 1);

    // Reset mid-operation discards the sample.
    s0 = strobes;
    send(16'd20000, 16'd3000, 16'd5000, 16'd7000, 1'b0, 1'b0);
    repeat (2) @(posedge aclk);
    #1 reset = 1'b1;
    @(posedge aclk); #1;
    reset = 1'b0;
    chk("midrst_in_ready", longint'(in_ready), 1);
    chk("midrst_beta", longint'(beta), 0);
    chk("midrst_d", longint'(d), 0);
    repeat (10) @(posedge aclk);
    #1;
    chk("midrst_no_strobe", longint'(strobes - s0), 0);

    // Back-to-back with in_valid held high.
    send(16'd16384, -16'sd8192, 16'd0, 16'd32767, 1'b1, 1'b1);
    acc1 = last_acc;
    send(16'd0, 16'd16384, 16'd0, 16'd32767, 1'b1, 1'b0);
    chk("b2b_spacing", longint'(last_acc - acc1), 6);

    // Random samples with random gaps.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge aclk);
      #1;
      send(rnd16(), rnd16(), rnd16(), rnd16(), 1'b1, 1'b0);
    end

    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge aclk);
    repeat (2) @(posedge aclk);
    #1;
    chk("drain_empty", longint'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/abc2dq_seq.md
Name: abc2dq_seq

Overview:
- Forward transform for current feedback: phase currents a, b → Clarke (alpha, beta) → Park (d, q), using supplied rotor-angle sin/cos.
- Inverse counterpart of the existing dq→abc modulator path; sits between the current ADC front-end and the dq current controllers.
- One shared signed multiplier, time-multiplexed by an FSM.
- Valid/ready input, one-cycle output strobe; outputs saturated.

Parameters:
- inout_width, 16, signed width of all data ports.
- inout_decimal_width, 15, fractional bits (Q1.15 by default).
- inv_sqrt3, 16'd18919, 1/sqrt(3) in Q(inout_decimal_width), treated as positive.

Ports:
- aclk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- ia  in  inout_width  phase-a current, signed.
- ib  in  inout_width  phase-b current, signed. ic is implied: ia+ib+ic=0.
- sin  in  inout_width  sine of electrical angle, signed Q.
- cos  in  inout_width  cosine of electrical angle, signed Q.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block idle, can accept.
- alpha  out  inout_width  registered Clarke alpha.
- beta  out  inout_width  registered Clarke beta, saturated.
- d  out  inout_width  direct component, saturated.
- q  out  inout_width  quadrature component, saturated.
- out_valid  out  1  one-cycle strobe; alpha/beta/d/q updated.

Behaviour:
- Reset (synchronous, active-high, any state):
  - state=IDLE, in_ready=1, out_valid=0.
  - alpha/beta/d/q=0; internal registers cleared.
  - An in-flight sample is discarded; no out_valid is produced for it.
- Accept: on a rising edge with in_valid&&in_ready, capture ia, ib, sin, cos; go to BETA.
  - in_valid outside IDLE is ignored.
  - Input changes after capture have no effect on the result.
- FSM, one state per cycle (acceptance edge = k):
  - IDLE: in_ready=1.
  - BETA (edge k+1): beta_r = sat((ia+2*ib) * inv_sqrt3 >>> F). Sum is held in W+2 bits.
  - M0 (edge k+2): acc = alpha_r*cos, with alpha_r = ia.
  - M1 (edge k+3): d_r = sat((acc + beta_r*sin) >>> F).
  - M2 (edge k+4): acc = -(alpha_r*sin).
  - M3 (edge k+5): q_r = sat((acc + beta_r*cos) >>> F). Load alpha/beta/d/q outputs together; out_valid=1 for the following cycle; go to IDLE.
- Latency and throughput:
  - out_valid is high in the cycle after edge k+5.
  - in_ready is high in that same cycle, so a back-to-back sample can be accepted on edge k+6.
  - Throughput is one sample per 6 cycles.
- Arithmetic:
  - Products are 2W bits; accumulator is 2W+2 bits.
  - Shift is arithmetic (>>>), i.e. floor rounding toward −inf. This matches the dq→abc path.
- Saturation: results are clamped to [-2^(W-1), 2^(W-1)-1]. Example: (-32768)*(-32768)>>>15 = 32768 → 32767.
- Outputs hold their last values between strobes.

Decomposition:
- Shared package abc2dq_pkg:
  - state enum IDLE, BETA, M0, M1, M2, M3;
  - default W/F;
  - INV_SQRT3 constant;
  - saturate(width) function.
- One sub-module: abc2dq_mac. It is the registered multiply-accumulate (a*b ± acc), with a clear/negate control, and is shared by all FSM steps.

Test Plan:
1. Pure a-axis: ia=16384, ib=-8192, sin=0, cos=32767, pulse in_valid → out_valid 6 cycles later; alpha=16384, beta=0, d=16383, q=0.
2. b-only: ia=0, ib=16384, sin=0, cos=32767 → beta=18919, d=0, q=18918.
3. Saturation: ia=ib=-32768, sin=0, cos=-32768 → beta=-32768, d=32767, q=32767. Also ia=ib=32767, cos=32767 → beta=32767, d=32766, q=32766.
4. Busy/hold: accept test 2, then change inputs and pulse in_valid at k+2 → in_ready=0 and pulse ignored; results are as in test 2; exactly one out_valid.
5. Reset mid-op: accept, assert reset at cycle k+3 for one cycle → next cycle in_ready=1, outputs 0, no out_valid for 10 cycles.
6. Back-to-back: in_valid held high with tests 1 then 2 → accepts at k and k+6; out_valid at k+6 and k+12 with matching results in order.
